// File: rtl/fetch_sequencer_pkg.sv
// Shared fetch-stage types and default sizes for the instruction-fetch sequencer.
package fetch_sequencer_pkg;

    localparam int PC_WIDTH     = 8;
    localparam int INSTR_WIDTH  = 16;
    localparam int RESET_VECTOR = 0;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_OUT  = 2'd2,
        S_HALT = 2'd3
    } fetch_state_t;

endpackage

// File: rtl/fetch_sequencer_if.sv
// Memory-side req/ack, decode-side valid/ready and execute-side redirect/halt bundle.
interface fetch_sequencer_if
    import fetch_sequencer_pkg::*;
#(
    parameter int WIDTH  = PC_WIDTH,
    parameter int IWIDTH = INSTR_WIDTH
) ();

    logic              imem_req;
    logic [WIDTH-1:0]  imem_addr;
    logic              imem_ack;
    logic [IWIDTH-1:0] imem_rdata;
    logic              inst_valid;
    logic [IWIDTH-1:0] inst_data;
    logic [WIDTH-1:0]  inst_pc;
    logic              inst_ready;
    logic              redirect_en;
    logic [WIDTH-1:0]  redirect_addr;
    logic              halt;
    logic              busy;

    // master is the fetch sequencer; slave is memory/decode/execute around it
    modport master (
        output imem_req, imem_addr, inst_valid, inst_data, inst_pc, busy,
        input  imem_ack, imem_rdata, inst_ready, redirect_en, redirect_addr, halt
    );

    modport slave (
        input  imem_req, imem_addr, inst_valid, inst_data, inst_pc, busy,
        output imem_ack, imem_rdata, inst_ready, redirect_en, redirect_addr, halt
    );

endinterface

// File: rtl/fetch_sequencer_pc_reg.sv
// Program counter with load and increment enables; load has priority, increment wraps.
module fetch_pc_reg
    import fetch_sequencer_pkg::*;
#(
    parameter int WIDTH      = PC_WIDTH,
    parameter int RESET_ADDR = RESET_VECTOR
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_i,
    input  logic [WIDTH-1:0] loadValue_i,
    input  logic             inc_i,
    output logic [WIDTH-1:0] pc_o
);

    localparam logic [WIDTH-1:0] RESET_PC = WIDTH'(RESET_ADDR);

    logic [WIDTH-1:0] pc_q, pc_d;

    always_comb begin
        pc_d = pc_q;
        if (load_i) begin
            pc_d = loadValue_i;
        end else if (inc_i) begin
            pc_d = pc_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc_o = pc_q;

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction-fetch controller: sequences memory req/ack, buffers the word for decode,
// and applies redirects/halt without ever abandoning an outstanding request.
module fetch_sequencer
    import fetch_sequencer_pkg::*;
#(
    parameter int WIDTH      = PC_WIDTH,
    parameter int IWIDTH     = INSTR_WIDTH,
    parameter int RESET_ADDR = RESET_VECTOR
) (
    input logic                clk,
    input logic                reset,
    fetch_sequencer_if.master  bus
);

    fetch_state_t      state_q, state_d;
    logic              kill_q, kill_d;
    logic [WIDTH-1:0]  pendingTarget_q, pendingTarget_d;
    logic [IWIDTH-1:0] instData_q, instData_d;
    logic [WIDTH-1:0]  instPc_q, instPc_d;
    logic [WIDTH-1:0]  pc;
    logic              pcLoad, pcInc;
    logic [WIDTH-1:0]  pcLoadValue;

    fetch_pc_reg #(.WIDTH(WIDTH), .RESET_ADDR(RESET_ADDR)) pcReg (
        .clk         (clk),
        .reset       (reset),
        .load_i      (pcLoad),
        .loadValue_i (pcLoadValue),
        .inc_i       (pcInc),
        .pc_o        (pc)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            kill_q          <= 1'b0;
            pendingTarget_q <= '0;
            instData_q      <= '0;
            instPc_q        <= '0;
        end else begin
            kill_q          <= kill_d;
            pendingTarget_q <= pendingTarget_d;
            instData_q      <= instData_d;
            instPc_q        <= instPc_d;
        end
    end

    // A redirect during an outstanding request only marks it killed; the request
    // itself runs to its ack so memory always sees a clean handshake.
    always_comb begin
        state_d         = state_q;
        kill_d          = kill_q;
        pendingTarget_d = pendingTarget_q;
        instData_d      = instData_q;
        instPc_d        = instPc_q;
        pcLoad          = 1'b0;
        pcInc           = 1'b0;
        pcLoadValue     = bus.redirect_addr;
        case (state_q)
            S_IDLE: begin
                pcLoad  = bus.redirect_en;
                state_d = bus.halt ? S_HALT : S_REQ;
            end
            S_REQ: begin
                if (bus.imem_ack) begin
                    if (bus.redirect_en) begin
                        pcLoad = 1'b1;
                        kill_d = 1'b0;
                    end else if (kill_q) begin
                        pcLoad      = 1'b1;
                        pcLoadValue = pendingTarget_q;
                        kill_d      = 1'b0;
                    end else begin
                        instData_d = bus.imem_rdata;
                        instPc_d   = pc;
                        pcInc      = 1'b1;
                        state_d    = S_OUT;
                    end
                end else if (bus.redirect_en) begin
                    kill_d          = 1'b1;
                    pendingTarget_d = bus.redirect_addr;
                end
            end
            S_OUT: begin
                if (bus.redirect_en) begin
                    pcLoad  = 1'b1;
                    state_d = bus.halt ? S_HALT : S_REQ;
                end else if (bus.inst_ready) begin
                    state_d = bus.halt ? S_HALT : S_REQ;
                end
            end
            S_HALT: begin
                pcLoad = bus.redirect_en;
                if (!bus.halt) begin
                    state_d = S_REQ;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // A redirect in S_OUT squashes the buffered word in the same cycle.
    always_comb begin
        bus.imem_req   = (state_q == S_REQ);
        bus.inst_valid = (state_q == S_OUT) && !bus.redirect_en;
        bus.busy       = (state_q == S_REQ) || (state_q == S_OUT);
    end

    assign bus.imem_addr = pc;
    assign bus.inst_data = instData_q;
    assign bus.inst_pc   = instPc_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Scenario bench for fetch_sequencer: hand-driven memory handshakes with a delivery scoreboard.
module tb_fetch_sequencer;
    import fetch_sequencer_pkg::*;

    localparam int W  = 8;
    localparam int IW = 16;

    typedef struct packed {
        logic [W-1:0]  pc;
        logic [IW-1:0] data;
    } delivery_t;

    logic      clk = 1'b0;
    logic      reset;
    int        compareCount  = 0;
    int        mismatchCount = 0;
    delivery_t expQ[$];
    delivery_t monExp;

    fetch_sequencer_if #(.WIDTH(W), .IWIDTH(IW)) bus ();

    fetch_sequencer #(.WIDTH(W), .IWIDTH(IW), .RESET_ADDR(0)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Every accepted instruction must match the oldest expected delivery.
    always @(negedge clk) begin
        if (reset === 1'b0 && bus.inst_valid === 1'b1 && bus.inst_ready === 1'b1) begin
            compareCount++;
            if (expQ.size() == 0) begin
                mismatchCount++;
                $display("[TB] FAIL delivery_unexpected got pc=%h data=%h exp=none", bus.inst_pc, bus.inst_data);
            end else begin
                monExp = expQ.pop_front();
                if ({bus.inst_pc, bus.inst_data} !== monExp) begin
                    mismatchCount++;
                    $display("[TB] FAIL delivery got pc=%h data=%h exp pc=%h data=%h",
                             bus.inst_pc, bus.inst_data, monExp.pc, monExp.data);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Wait for a request, check its address and hold, then ack 'delay' cycles after it appeared.
    task automatic serve(input logic [W-1:0] expAddr, input int delay, input logic [IW-1:0] data,
                         input bit deliver, input string tag);
        bit seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            seen = (bus.imem_req === 1'b1);
        end
        compareCount++;
        if (!seen) begin
            mismatchCount++;
            $display("[TB] FAIL %s_req_timeout got=no request exp=request within 20 cycles", tag);
        end else if (bus.imem_addr !== expAddr) begin
            mismatchCount++;
            $display("[TB] FAIL %s_addr got=%h exp=%h", tag, bus.imem_addr, expAddr);
        end
        for (int c = 1; c < delay; c++) begin
            tick();
            compareCount++;
            if ({bus.imem_req, bus.imem_addr} !== {1'b1, expAddr}) begin
                mismatchCount++;
                $display("[TB] FAIL %s_hold got req=%b addr=%h exp req=1 addr=%h", tag, bus.imem_req, bus.imem_addr, expAddr);
            end
        end
        tick();
        bus.imem_ack   = 1'b1;
        bus.imem_rdata = data;
        if (deliver) expQ.push_back({expAddr, data});
        tick();
        bus.imem_ack   = 1'b0;
        bus.imem_rdata = '0;
    endtask

    task automatic test_reset();
        bus.imem_ack = 1'b0; bus.imem_rdata = '0; bus.inst_ready = 1'b1;
        bus.redirect_en = 1'b0; bus.redirect_addr = '0; bus.halt = 1'b0;
        reset = 1'b0;
        #1 reset = 1'b1;
        #2;
        compareCount++;
        if ({bus.imem_req, bus.inst_valid, bus.busy, bus.imem_addr, bus.inst_data, bus.inst_pc} !== '0) begin
            mismatchCount++;
            $display("[TB] FAIL reset_outputs got req=%b valid=%b busy=%b addr=%h data=%h pc=%h exp all zero",
                     bus.imem_req, bus.inst_valid, bus.busy, bus.imem_addr, bus.inst_data, bus.inst_pc);
        end
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_basic_fetch();
        serve(8'h00, 2, 16'hA5A5, 1'b1, "t1");
        compareCount++;
        if ({bus.inst_valid, bus.inst_data, bus.inst_pc, bus.imem_req} !== {1'b1, 16'hA5A5, 8'h00, 1'b0}) begin
            mismatchCount++;
            $display("[TB] FAIL t1_out got valid=%b data=%h pc=%h req=%b exp 1 a5a5 00 0",
                     bus.inst_valid, bus.inst_data, bus.inst_pc, bus.imem_req);
        end
        tick();
        compareCount++;
        if ({bus.imem_req, bus.imem_addr, bus.busy} !== {1'b1, 8'h01, 1'b1}) begin
            mismatchCount++;
            $display("[TB] FAIL t1_next_req got req=%b addr=%h busy=%b exp 1 01 1", bus.imem_req, bus.imem_addr, bus.busy);
        end
    endtask

    task automatic test_backpressure();
        serve(8'h01, 1, 16'h1111, 1'b1, "t2");
        bus.inst_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            compareCount++;
            if ({bus.inst_valid, bus.inst_data, bus.inst_pc, bus.imem_req} !== {1'b1, 16'h1111, 8'h01, 1'b0}) begin
                mismatchCount++;
                $display("[TB] FAIL t2_stall%0d got valid=%b data=%h pc=%h req=%b exp 1 1111 01 0",
                         k, bus.inst_valid, bus.inst_data, bus.inst_pc, bus.imem_req);
            end
            tick();
        end
        bus.inst_ready = 1'b1;
        tick();
        compareCount++;
        if ({bus.imem_req, bus.imem_addr} !== {1'b1, 8'h02}) begin
            mismatchCount++;
            $display("[TB] FAIL t2_resume got req=%b addr=%h exp 1 02", bus.imem_req, bus.imem_addr);
        end
    endtask

    task automatic test_redirect_pending();
        serve(8'h02, 1, 16'h2222, 1'b1, "t3a");
        tick();
        bus.redirect_en = 1'b1; bus.redirect_addr = 8'h40;
        tick();
        bus.redirect_en = 1'b0;
        for (int c = 1; c < 3; c++) begin
            compareCount++;
            if ({bus.imem_req, bus.imem_addr} !== {1'b1, 8'h03}) begin
                mismatchCount++;
                $display("[TB] FAIL t3_hold got req=%b addr=%h exp 1 03", bus.imem_req, bus.imem_addr);
            end
            tick();
        end
        bus.imem_ack = 1'b1; bus.imem_rdata = 16'hDEAD;
        tick();
        bus.imem_ack = 1'b0; bus.imem_rdata = '0;
        compareCount++;
        if ({bus.inst_valid, bus.imem_req, bus.imem_addr} !== {1'b0, 1'b1, 8'h40}) begin
            mismatchCount++;
            $display("[TB] FAIL t3_discard got valid=%b req=%b addr=%h exp 0 1 40", bus.inst_valid, bus.imem_req, bus.imem_addr);
        end
        serve(8'h40, 1, 16'h4040, 1'b1, "t3b");
    endtask

    task automatic test_redirect_rules();
        tick();
        bus.redirect_en = 1'b1; bus.redirect_addr = 8'h10;
        tick();
        bus.redirect_addr = 8'h20;
        tick();
        bus.redirect_en = 1'b0;
        bus.imem_ack = 1'b1; bus.imem_rdata = 16'hBEEF;
        tick();
        bus.imem_ack = 1'b0;
        compareCount++;
        if ({bus.inst_valid, bus.imem_req, bus.imem_addr} !== {1'b0, 1'b1, 8'h20}) begin
            mismatchCount++;
            $display("[TB] FAIL last_target_wins got valid=%b req=%b addr=%h exp 0 1 20", bus.inst_valid, bus.imem_req, bus.imem_addr);
        end
        bus.imem_ack = 1'b1; bus.redirect_en = 1'b1; bus.redirect_addr = 8'h30;
        tick();
        bus.imem_ack = 1'b0; bus.redirect_en = 1'b0; bus.imem_rdata = '0;
        compareCount++;
        if ({bus.inst_valid, bus.imem_req, bus.imem_addr} !== {1'b0, 1'b1, 8'h30}) begin
            mismatchCount++;
            $display("[TB] FAIL redirect_with_ack got valid=%b req=%b addr=%h exp 0 1 30", bus.inst_valid, bus.imem_req, bus.imem_addr);
        end
        serve(8'h30, 1, 16'h3333, 1'b0, "t_out");
        bus.redirect_en = 1'b1; bus.redirect_addr = 8'h50;
        #1;
        compareCount++;
        if (bus.inst_valid !== 1'b0) begin
            mismatchCount++;
            $display("[TB] FAIL out_redirect_squash got valid=%b exp 0", bus.inst_valid);
        end
        tick();
        bus.redirect_en = 1'b0;
        compareCount++;
        if ({bus.imem_req, bus.imem_addr} !== {1'b1, 8'h50}) begin
            mismatchCount++;
            $display("[TB] FAIL out_redirect_req got req=%b addr=%h exp 1 50", bus.imem_req, bus.imem_addr);
        end
    endtask

    task automatic test_wrap();
        bus.imem_ack = 1'b1; bus.redirect_en = 1'b1; bus.redirect_addr = 8'hFF;
        tick();
        bus.imem_ack = 1'b0; bus.redirect_en = 1'b0;
        serve(8'hFF, 1, 16'h0FF0, 1'b1, "t4");
        compareCount++;
        if (bus.inst_pc !== 8'hFF) begin
            mismatchCount++;
            $display("[TB] FAIL t4_inst_pc got=%h exp=ff", bus.inst_pc);
        end
        tick();
        compareCount++;
        if ({bus.imem_req, bus.imem_addr} !== {1'b1, 8'h00}) begin
            mismatchCount++;
            $display("[TB] FAIL t4_wrap got req=%b addr=%h exp 1 00", bus.imem_req, bus.imem_addr);
        end
    endtask

    task automatic test_halt();
        bus.halt = 1'b1;
        serve(8'h00, 2, 16'h5A5A, 1'b1, "t5");
        compareCount++;
        if ({bus.inst_valid, bus.inst_pc, bus.busy} !== {1'b1, 8'h00, 1'b1}) begin
            mismatchCount++;
            $display("[TB] FAIL t5_delivered got valid=%b pc=%h busy=%b exp 1 00 1", bus.inst_valid, bus.inst_pc, bus.busy);
        end
        for (int k = 0; k < 4; k++) begin
            tick();
            compareCount++;
            if ({bus.imem_req, bus.busy, bus.inst_valid} !== 3'b000) begin
                mismatchCount++;
                $display("[TB] FAIL t5_halted%0d got req=%b busy=%b valid=%b exp 0 0 0", k, bus.imem_req, bus.busy, bus.inst_valid);
            end
        end
        bus.halt = 1'b0;
        tick();
        compareCount++;
        if ({bus.imem_req, bus.imem_addr, bus.busy} !== {1'b1, 8'h01, 1'b1}) begin
            mismatchCount++;
            $display("[TB] FAIL t5_resume got req=%b addr=%h busy=%b exp 1 01 1", bus.imem_req, bus.imem_addr, bus.busy);
        end
    endtask

    task automatic test_reset_mid_request();
        bit seen = 1'b0;
        #2 reset = 1'b1;
        #1;
        compareCount++;
        if ({bus.imem_req, bus.inst_valid, bus.busy, bus.imem_addr, bus.inst_data, bus.inst_pc} !== '0) begin
            mismatchCount++;
            $display("[TB] FAIL t6_async_reset got req=%b valid=%b busy=%b addr=%h data=%h pc=%h exp all zero",
                     bus.imem_req, bus.inst_valid, bus.busy, bus.imem_addr, bus.inst_data, bus.inst_pc);
        end
        tick();
        tick();
        reset = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            seen = (bus.imem_req === 1'b1);
        end
        compareCount++;
        if (!seen || {bus.imem_addr, bus.busy} !== {8'h00, 1'b1}) begin
            mismatchCount++;
            $display("[TB] FAIL t6_first_req got seen=%b addr=%h busy=%b exp 1 00 1", seen, bus.imem_addr, bus.busy);
        end
    endtask

    initial begin
        test_reset();
        test_basic_fetch();
        test_backpressure();
        test_redirect_pending();
        test_redirect_rules();
        test_wrap();
        test_halt();
        test_reset_mid_request();
        compareCount++;
        if (expQ.size() != 0) begin
            mismatchCount++;
            $display("[TB] FAIL undelivered got=%0d pending exp=0", expQ.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
        $finish;
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog got=timeout exp=completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
